// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue controller:
//     - data/opcode widths and the packed command word layout
//     - ALU opcode encodings
//     - issue-controller FSM state encoding
//     - helper: divide/modulo-by-zero detection
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int CMD_W  = OP_W + 2 * DATA_W + 1;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b011;
    localparam logic [OP_W-1:0] OP_MOD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
    localparam logic [OP_W-1:0] OP_GT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              use_acc;
    } cmd_t;

    // Division and modulo by zero are the only operations the ALU cannot
    // answer meaningfully; the controller substitutes an error result.
    function automatic logic div_by_zero(input logic [OP_W-1:0]   sel,
                                         input logic [DATA_W-1:0] divisor);
        return ((sel == OP_DIV) || (sel == OP_MOD)) && (divisor == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous command FIFO, no write-to-read bypass.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset (pointers/count)
//     i_push, i_wdata   write strobe and data (caller guarantees !o_full)
//     i_pop,  o_rdata   read strobe and head entry (caller guarantees !o_empty)
//     o_full, o_empty   occupancy flags, derived from the count register
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage carries no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Sequential front/back-end for the combinational 4-bit ALU. Commands are
//   queued in alu_cmd_fifo, issued one at a time as registered operands, and
//   the ALU result is captured into a valid/ready result port. Divide/modulo
//   by zero yields res_data=0, res_err=1. A 4-bit accumulator holds the last
//   captured result so a command can use it in place of operand A.
//
//   Ports:
//     clk, rst_n                         clock, async active-low reset
//     cmd_valid/cmd_ready                command handshake (ready = !full)
//     cmd_sel, cmd_a, cmd_b, cmd_use_acc command fields
//     alu_sel, alu_in0, alu_in1          registered operands to the ALU
//     alu_out                            ALU result
//     res_valid/res_ready                result handshake
//     res_data, res_err                  result value and div/mod-by-zero flag
//     acc                                accumulator
//     stat_ops, stat_errs                (ALU_ISSUE_STATS_EN only) saturating
//                                        counts of accepted / errored results
//
//   Optional feature macro: ALU_ISSUE_STATS_EN
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic [OP_W-1:0]   alu_sel,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
`ifdef ALU_ISSUE_STATS_EN
    output logic [7:0]        stat_ops,
    output logic [7:0]        stat_errs,
`endif
    output logic [DATA_W-1:0] acc
);

    state_t            r_state;
    logic [OP_W-1:0]   r_alu_sel;
    logic [DATA_W-1:0] r_alu_in0;
    logic [DATA_W-1:0] r_alu_in1;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_err;
    logic [DATA_W-1:0] r_acc;

    cmd_t              w_push_cmd;
    cmd_t              w_pop_cmd;
    logic [CMD_W-1:0]  w_pop_raw;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_push_cmd = '{sel: cmd_sel, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
    assign w_pop_cmd  = cmd_t'(w_pop_raw);

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    // Pop from IDLE, or in the same edge that a held result is consumed.
    assign w_pop     = !w_empty &&
                       ((r_state == IDLE) || ((r_state == RESP) && res_ready));

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_pop_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_alu_sel   <= '0;
            r_alu_in0   <= '0;
            r_alu_in1   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_acc       <= '0;
        end else begin
            // acc only changes at capture, so at pop it holds the previous result.
            if (w_pop) begin
                r_alu_sel <= w_pop_cmd.sel;
                r_alu_in0 <= w_pop_cmd.use_acc ? r_acc : w_pop_cmd.a;
                r_alu_in1 <= w_pop_cmd.b;
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) r_state <= ISSUE;
                end
                ISSUE: begin
                    if (div_by_zero(r_alu_sel, r_alu_in1)) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                        r_acc      <= '0;
                    end else begin
                        r_res_data <= alu_out;
                        r_res_err  <= 1'b0;
                        r_acc      <= alu_out;
                    end
                    r_res_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_pop ? ISSUE : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_sel   = r_alu_sel;
    assign alu_in0   = r_alu_in0;
    assign alu_in1   = r_alu_in1;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign acc       = r_acc;

`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] r_stat_ops;
    logic [7:0] r_stat_errs;
    logic       w_accept;

    assign w_accept = r_res_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops  <= '0;
            r_stat_errs <= '0;
        end else if (w_accept) begin
            if (r_stat_ops != 8'hFF)              r_stat_ops  <= r_stat_ops + 1'b1;
            if (r_res_err && r_stat_errs != 8'hFF) r_stat_errs <= r_stat_errs + 1'b1;
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl with a behavioural stand-in for the
//   team's 4-bit combinational ALU. Define ALU_ISSUE_STATS_EN to also cover
//   the statistics counters.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_sel = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic       cmd_use_acc = 1'b0;
    logic [2:0] alu_sel;
    logic [3:0] alu_in0;
    logic [3:0] alu_in1;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_err;
    logic [3:0] acc;
`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] stat_ops;
    logic [7:0] stat_errs;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_sel     (cmd_sel),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_sel     (alu_sel),
        .alu_in0     (alu_in0),
        .alu_in1     (alu_in1),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
`ifdef ALU_ISSUE_STATS_EN
        .stat_ops    (stat_ops),
        .stat_errs   (stat_errs),
`endif
        .acc         (acc)
    );

    // Behavioural ALU: 4-bit wrap-around results.
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'b000: alu_out = alu_in0;
            3'b001: alu_out = alu_in0 + alu_in1;
            3'b010: alu_out = alu_in0 - alu_in1;
            3'b011: alu_out = (alu_in1 != 0) ? alu_in0 / alu_in1 : 4'h0;
            3'b100: alu_out = (alu_in1 != 0) ? alu_in0 % alu_in1 : 4'h0;
            3'b101: alu_out = alu_in0 << alu_in1;
            3'b110: alu_out = alu_in0 >> alu_in1;
            default: alu_out = {3'b000, (alu_in0 > alu_in1)};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle of cmd_valid; returns #1 after the sampling edge.
    task automatic push(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                        input logic u);
        cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = u; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a result with res_ready=1, record it, let it be consumed.
    task automatic get_res(output logic [3:0] d, output logic e, output logic ok);
        ok = 1'b0; d = '0; e = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (res_valid) begin
                d = res_data; e = res_err; ok = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [3:0] d;
    logic       e;
    logic       ok;
    int         seen;

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data",  res_data, 0);
        chk("rst_res_err",   res_err, 0);
        chk("rst_acc",       acc, 0);
        chk("rst_alu_ops",   {alu_sel, alu_in0, alu_in1}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD: latency 2 cycles after accept
        res_ready = 1'b1;
        push(3'b001, 4'd3, 4'd5, 1'b0);             // E0
        chk("lat_e0_valid", res_valid, 0);
        @(posedge clk); #1;                          // E1: operands presented
        chk("lat_e1_ops", {alu_sel, alu_in0, alu_in1}, {3'b001, 4'd3, 4'd5});
        chk("lat_e1_valid", res_valid, 0);
        @(posedge clk); #1;                          // E2: captured
        chk("lat_e2_valid", res_valid, 1);
        chk("add_data", res_data, 8);
        chk("add_err",  res_err, 0);
        chk("add_acc",  acc, 8);
        @(posedge clk); #1;
        chk("add_consumed", res_valid, 0);

        // Divide by zero, then modulo
        push(3'b011, 4'd9, 4'd0, 1'b0);
        get_res(d, e, ok);
        chk("div0_ok", ok, 1);
        chk("div0_data", d, 0);
        chk("div0_err",  e, 1);
        chk("div0_acc",  acc, 0);
        push(3'b100, 4'd9, 4'd4, 1'b0);
        get_res(d, e, ok);
        chk("mod_ok", ok, 1);
        chk("mod_data", d, 1);
        chk("mod_err",  e, 0);

        // Accumulator chain: 2+3=5, 5+4=9, 9<<1=18 -> 2
        res_ready = 1'b0;
        push(3'b001, 4'd2, 4'd3, 1'b0);
        push(3'b001, 4'd0, 4'd4, 1'b1);
        push(3'b101, 4'd0, 4'd1, 1'b1);
        res_ready = 1'b1;
        get_res(d, e, ok); chk("chain0", {ok, d}, {1'b1, 4'd5});
        get_res(d, e, ok); chk("chain1", {ok, d}, {1'b1, 4'd9});
        get_res(d, e, ok); chk("chain2", {ok, d}, {1'b1, 4'd2});
        chk("chain_acc", acc, 2);

        // Backpressure: 4 in FIFO + 1 in RESP
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(3'b001, 4'(i + 1), 4'd1, 1'b0);
            if (i == 3) chk("bp_ready_3", cmd_ready, 1);
        end
        chk("bp_ready_full", cmd_ready, 0);
        chk("bp_hold_valid", res_valid, 1);
        chk("bp_hold_data",  res_data, 2);
        push(3'b000, 4'd15, 4'd0, 1'b0);            // refused: FIFO full
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stable_valid", res_valid, 1);
        chk("bp_stable_data",  res_data, 2);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            get_res(d, e, ok);
            chk("bp_drain", {ok, d}, {1'b1, 4'(i + 2)});
        end
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_extra", res_valid, 0);
        chk("bp_ready_empty", cmd_ready, 1);

        // Asynchronous reset while in ISSUE with 3 queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(3'b001, 4'd1, 4'd1, 1'b0);
        res_ready = 1'b1;
        push(3'b001, 4'd1, 4'd1, 1'b0);             // consume + pop + push
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_acc",   acc, 0);
`ifdef ALU_ISSUE_STATS_EN
        chk("arst_stat_ops", stat_ops, 0);
        chk("arst_stat_errs", stat_errs, 0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        chk("arst_no_result", seen, 0);

`ifdef ALU_ISSUE_STATS_EN
        push(3'b001, 4'd1, 4'd2, 1'b0); get_res(d, e, ok);
        push(3'b010, 4'd3, 4'd5, 1'b0); get_res(d, e, ok);
        chk("sub_wrap", d, 4'hE);
        push(3'b111, 4'd7, 4'd2, 1'b0); get_res(d, e, ok);
        push(3'b100, 4'd7, 4'd0, 1'b0); get_res(d, e, ok);
        chk("stat_ops4",  stat_ops, 4);
        chk("stat_errs1", stat_errs, 1);
        for (int i = 0; i < 296; i++) begin
            push(3'b001, 4'd1, 4'd1, 1'b0);
            get_res(d, e, ok);
        end
        chk("stat_ops_sat",  stat_ops, 8'hFF);
        chk("stat_errs_end", stat_errs, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front/back-end for the team's combinational 4-bit ALU (ports sel[2:0], IN0[3:0], IN1[3:0], OUT[3:0]).
- Buffers operation commands in a small FIFO and drives registered operands into the ALU.
- Captures the ALU result into a valid/ready result port.
- Guards divide/modulo by zero and keeps a 4-bit accumulator so commands can chain on the previous result.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_sel  in  3  ALU opcode.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_use_acc  in  1  substitute accumulator for operand A.
- alu_sel  out  3  to ALU sel.
- alu_in0  out  4  to ALU IN0.
- alu_in1  out  4  to ALU IN1.
- alu_out  in  4  from ALU OUT.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  4  result.
- res_err  out  1  divide/modulo by zero on this result.
- acc  out  4  accumulator (last accepted-into-result value).

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: cmd_ready=1 (FIFO empty), alu_sel/alu_in0/alu_in1=0, res_valid=0, res_data=0, res_err=0, acc=0, FSM=IDLE, FIFO pointers and count=0.
- Reset mid-operation: all in-flight and queued commands are discarded; no result is emitted.
- FIFO push: on cmd_valid && cmd_ready at a clock edge. No push when full. No bypass: a push into an empty FIFO is not poppable in the same cycle.
- Pop loads the operand registers:
  - alu_sel <= sel
  - alu_in0 <= use_acc ? acc : a
  - alu_in1 <= b
- FSM, IDLE: if FIFO not empty, pop and go to ISSUE; else stay.
- FSM, ISSUE (ALU output settles combinationally):
  - Next edge captures the result and goes to RESP.
  - If alu_sel is 011 or 100 and alu_in1==0: res_data<=0, res_err<=1, ALU output ignored.
  - Otherwise res_data<=alu_out, res_err<=0.
  - res_valid<=1; acc<=captured res_data value.
- FSM, RESP: hold res_valid, res_data and res_err stable while !res_ready. On res_ready:
  - res_valid<=0.
  - If FIFO not empty, pop in the same edge and go to ISSUE; else go to IDLE.
- Latency: command accepted at edge E0 into an empty, idle block; operands presented after E1; res_valid high after E2 (2 cycles).
- Throughput: one result per 2 cycles with res_ready held high.
- Ordering: strict FIFO order; one command in the ALU at a time.
- Arithmetic: all 4-bit, wrap-around from the ALU is passed through unchanged (e.g. 3-5 = 4'hE). The block performs no arithmetic except the zero check.
- Simultaneous events: a push and a pop in the same edge are allowed (count unchanged). cmd_ready is combinational from count only, not from cmd_valid.
- Accumulator: updated only on capture, so the pop-time acc value always reflects the previous command's result. An error result sets acc=0.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, adds two outputs, stat_ops[7:0] and stat_errs[7:0], both reset to 0.
  - stat_ops counts results accepted (res_valid && res_ready).
  - stat_errs counts accepted results with res_err=1.
  - Both counters saturate at 8'hFF.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams: OP_PASS=000, OP_ADD=001, OP_SUB=010, OP_DIV=011, OP_MOD=100, OP_SHL=101, OP_SHR=110, OP_GT=111.
  - FSM state encodings: IDLE, ISSUE, RESP.
  - Data width 4 and opcode width 3.
- One natural sub-module: alu_cmd_fifo (parameterised synchronous FIFO, width 3+4+4+1=12, same clk/rst_n).
- The ALU itself is instantiated alongside in the integrating top, not inside this block.

Test Plan:
- Reset then single command sel=001,a=3,b=5,res_ready=1 → res_valid high 2 cycles after accept, res_data=8, res_err=0, acc=8.
- sel=011,a=9,b=0 → res_data=0, res_err=1, acc=0. Then sel=100,a=9,b=4 → res_data=1, res_err=0.
- Chain: sel=001,a=2,b=3 then sel=001,use_acc=1,b=4 then sel=101,use_acc=1 → results 5, 9, 2 (18 wraps to 4'h2), in order.
- Backpressure: hold res_ready=0 and push 5 commands with FIFO_DEPTH=4 → cmd_ready drops after 4 FIFO entries plus 1 in RESP. res_data stays stable. Releasing res_ready drains all 5 in order.
- Assert rst_n low while in ISSUE with 3 queued → res_valid=0 and cmd_ready=1 immediately (asynchronous). No result appears after release.
- With ALU_ISSUE_STATS_EN: 3 good commands and 1 div-by-zero accepted → stat_ops=4, stat_errs=1. 300 accepted results → stat_ops saturates at 8'hFF.
